// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal register (hold / shift right / shift left / parallel load)
// with a saturating same-direction shift counter and a registered "full" flag.
// Optional build macro USR_ROTATE_EN adds a 'rot' input that turns shifts into rotates.
module univ_shift_reg #(
   parameter int unsigned             WIDTH   = 8,
   parameter logic [WIDTH-1:0]        RST_VAL = '0,
   parameter int unsigned             CW      = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_r,
   input  logic             sin_l,
`ifdef USR_ROTATE_EN
   input  logic             rot,
`endif
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CW-1:0]    cnt,
   output logic             full
);

   typedef enum logic {DirRight = 1'b0, DirLeft = 1'b1} dir_e;

   localparam logic [CW-1:0] CntMax = CW'(WIDTH);

   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             full_q, full_d;
   dir_e             dir_q, dir_d;

   logic             in_r, in_l;
   logic [CW-1:0]    cnt_inc;

   // Serial bits entering the register; rotate feeds back the bit leaving the other end.
   always_comb begin
      in_r = sin_r;
      in_l = sin_l;
`ifdef USR_ROTATE_EN
      if (rot) begin
         in_r = q_q[0];
         in_l = q_q[WIDTH-1];
      end
`endif
   end

   // Saturating increment used when a shift continues in the same direction.
   always_comb begin
      cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
   end

   // Next-state decode for contents, counter, full flag and last shift direction.
   always_comb begin
      q_d    = q_q;
      cnt_d  = cnt_q;
      full_d = full_q;
      dir_d  = dir_q;
      if (en) begin
         unique case (mode)
            2'b00: begin
               // hold
            end
            2'b01: begin
               q_d    = {in_r, q_q[WIDTH-1:1]};
               cnt_d  = (dir_q == DirRight) ? cnt_inc : CW'(1);
               dir_d  = DirRight;
               full_d = (cnt_d == CntMax);
            end
            2'b10: begin
               q_d    = {q_q[WIDTH-2:0], in_l};
               cnt_d  = (dir_q == DirLeft) ? cnt_inc : CW'(1);
               dir_d  = DirLeft;
               full_d = (cnt_d == CntMax);
            end
            2'b11: begin
               // load keeps the last direction so a following shift continues the old run rule
               q_d    = d;
               cnt_d  = '0;
               full_d = 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q    <= RST_VAL;
         cnt_q  <= '0;
         full_q <= 1'b0;
         dir_q  <= DirRight;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
         dir_q  <= dir_d;
      end
   end

   assign q      = q_q;
   assign cnt    = cnt_q;
   assign full   = full_q;
   assign sout_r = q_q[0];
   assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RST_VAL=0): directed cases plus
// randomized operations compared against a run-length based reference model.
module tb_univ_shift_reg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CW    = $clog2(WIDTH + 1);

   logic             clk;
   logic             rst;
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin_r;
   logic             sin_l;
   logic             rot;
   logic [WIDTH-1:0] q;
   logic             sout_r;
   logic             sout_l;
   logic [CW-1:0]    cnt;
   logic             full;

   int checks;
   int failures;

   // Reference model: contents as an integer, plus the length of the current same-direction run.
   int unsigned m_q;
   int          m_run;
   int          m_dir;  // 0 = right, 1 = left

   univ_shift_reg #(
      .WIDTH  (WIDTH),
      .RST_VAL(8'h00)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .mode  (mode),
      .d     (d),
      .sin_r (sin_r),
      .sin_l (sin_l),
`ifdef USR_ROTATE_EN
      .rot   (rot),
`endif
      .q     (q),
      .sout_r(sout_r),
      .sout_l(sout_l),
      .cnt   (cnt),
      .full  (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      int exp_cnt;
      exp_cnt = (m_run < WIDTH) ? m_run : WIDTH;
      check({tag, ".q"}, 32'(q), m_q);
      check({tag, ".cnt"}, 32'(cnt), 32'(exp_cnt));
      check({tag, ".full"}, 32'(full), 32'(m_run >= WIDTH));
      check({tag, ".sout_r"}, 32'(sout_r), m_q & 1);
      check({tag, ".sout_l"}, 32'(sout_l), (m_q >> (WIDTH - 1)) & 1);
   endtask

   task automatic model_reset();
      m_q   = 0;
      m_run = 0;
      m_dir = 0;
   endtask

   task automatic model_shift(input int dir, input int unsigned in_bit);
      if (dir == 0) m_q = (m_q >> 1) | (in_bit << (WIDTH - 1));
      else          m_q = ((m_q << 1) | in_bit) & ((1 << WIDTH) - 1);
      if (m_dir == dir) begin
         if (m_run < WIDTH) m_run++;
      end else begin
         m_run = 1;
         m_dir = dir;
      end
   endtask

   // Drives one operation, clocks it and compares against the model.
   task automatic do_op(input string tag, input logic e, input logic [1:0] m,
                        input logic [WIDTH-1:0] dd, input logic sr, input logic sl,
                        input logic r);
      int unsigned bit_r, bit_l;
      en = e; mode = m; d = dd; sin_r = sr; sin_l = sl; rot = r;
      @(posedge clk);
      #1;
      bit_r = sr;
      bit_l = sl;
`ifdef USR_ROTATE_EN
      if (r) begin
         bit_r = m_q & 1;
         bit_l = (m_q >> (WIDTH - 1)) & 1;
      end
`endif
      if (e) begin
         case (m)
            2'b01: model_shift(0, bit_r);
            2'b10: model_shift(1, bit_l);
            2'b11: begin m_q = dd; m_run = 0; end
            default: ;
         endcase
      end
      check_all(tag);
   endtask

   // Pulses reset between edges and checks that state clears without a clock edge.
   task automatic mid_reset(input string tag);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      #2 rst = 1'b1;
   endtask

   initial begin
      logic [7:0] pat;
      checks = 0; failures = 0;
      en = 0; mode = 2'b00; d = '0; sin_r = 0; sin_l = 0; rot = 0;
      rst = 1'b0;
      model_reset();
      #3 check_all("reset");
      #9 rst = 1'b1;

      // Hold with en=0 while mode requests a load
      for (int i = 0; i < 3; i++) do_op("hold_en0", 1'b0, 2'b11, 8'hFF, 1'b1, 1'b1, 1'b0);
      check("hold_q_const", 32'(q), 32'h00);

      // Serial right fill
      pat = 8'b0100_1101;  // sin_r sequence 1,0,1,1,0,0,1,0 taken from bit 0 upward
      for (int i = 0; i < 8; i++) do_op("fill_r", 1'b1, 2'b01, 8'h00, pat[i], 1'b0, 1'b0);
      check("fill_q_4d", 32'(q), 32'h4D);
      check("fill_full", 32'(full), 32'h1);
      do_op("fill_r9", 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
      check("fill9_q_a6", 32'(q), 32'hA6);
      check("fill9_cnt", 32'(cnt), 32'd8);

      // mode=00 with en=1 holds
      do_op("hold_m0", 1'b1, 2'b00, 8'h55, 1'b1, 1'b1, 1'b0);

      // Load then left shift
      do_op("load81", 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
      do_op("left1", 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0);
      check("left1_q_02", 32'(q), 32'h02);
      check("left1_cnt", 32'(cnt), 32'd1);

      // Direction change
      for (int i = 0; i < 3; i++) do_op("dir_r", 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
      check("dir_cnt3", 32'(cnt), 32'd3);
      do_op("dir_l", 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
      check("dir_cnt1", 32'(cnt), 32'd1);

      // Full clears on direction change after saturation
      for (int i = 0; i < 10; i++) do_op("sat_l", 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
      do_op("sat_r", 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);

      // Async reset mid-operation
      for (int i = 0; i < 5; i++) do_op("pre_rst", 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
      mid_reset("async_rst");
      do_op("post_rst", 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);

`ifdef USR_ROTATE_EN
      do_op("rot_load", 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
      do_op("rot_r", 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1);
      check("rot_r_c0", 32'(q), 32'hC0);
      do_op("rot_l", 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b1);
      do_op("rot_l", 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b1);
      check("rot_l_03", 32'(q), 32'h03);
      check("rot_l_cnt", 32'(cnt), 32'd2);
`endif

      // Randomized operations; modes are sticky so long runs reach saturation
      begin
         logic [1:0] rm;
         rm = 2'b01;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) rm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) mid_reset("rnd_rst");
            do_op("rnd", 1'($urandom_range(0, 9) != 0), rm, 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit enable/reset storage cells: a WIDTH-bit universal register with hold, shift-right, shift-left and parallel-load modes.
- Adds a shift counter and a "full" flag, so serial-to-parallel conversion can be detected without external logic.
- Sits between serial front-ends and parallel datapaths in the sequential-systems library.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- RST_VAL, 0, value loaded into q on reset; WIDTH bits.
- CW, $clog2(WIDTH+1), counter width. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  operation enable; 0 = everything holds.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input entering at the MSB on a right shift.
- sin_l  input  1  serial input entering at the LSB on a left shift.
- q  output  WIDTH  register contents.
- sout_r  output  1  q[0], combinational from q.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- cnt  output  CW  shifts since the last load, reset, or direction change; saturates at WIDTH.
- full  output  1  registered; 1 when cnt == WIDTH.

Behaviour:
- Reset:
  - rst=0 takes effect immediately and asynchronously, independent of clk: q=RST_VAL, cnt=0, full=0, last_dir=right.
  - Reset mid-shift discards all progress.
  - On release, the first active edge operates normally.
- en=0: q, cnt, full and last_dir hold, regardless of mode.
- en=1, mode=00: same as en=0 (hold).
- en=1, mode=01 (shift right):
  - q <= {sin_r, q[WIDTH-1:1]}.
  - If last_dir==right: cnt <= min(cnt+1, WIDTH). Otherwise cnt <= 1 and last_dir <= right.
- en=1, mode=10 (shift left):
  - q <= {q[WIDTH-2:0], sin_l}.
  - If last_dir==left: cnt <= min(cnt+1, WIDTH). Otherwise cnt <= 1 and last_dir <= left.
- en=1, mode=11 (load): q <= d, cnt <= 0, full <= 0; last_dir unchanged.
- full:
  - Registered alongside cnt: full <= (next cnt == WIDTH), i.e. it asserts on the same edge that cnt reaches WIDTH.
  - Stays 1 while further same-direction shifts occur, because cnt saturates.
  - Clears on load, reset, or direction change.
- Latency: one edge for every operation. Serial outputs reflect q combinationally, with zero added latency.
- Shifted-out bits are lost; there is no wrap unless the optional feature is enabled.
- Internal state is q, cnt, full and last_dir (1 bit). No other storage.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined:
  - Adds input port rot (1 bit).
  - When rot=1, right shift is q <= {q[0], q[WIDTH-1:1]} and left shift is q <= {q[WIDTH-2:0], q[WIDTH-1]}; sin_r and sin_l are ignored.
  - cnt and full update exactly as for normal shifts.
  - rot=0 behaves identically to the macro being undefined.
- Undefined: no rot port; shifts always take sin_r and sin_l.

Test Plan (WIDTH=8, RST_VAL=0):
- Reset/hold: rst=0, then release; en=0, mode=11, d=8'hFF for 3 edges -> q=8'h00, cnt=0, full=0.
- Serial right fill: en=1, mode=01, sin_r pattern 1,0,1,1,0,0,1,0 over 8 edges -> q=8'h4D, cnt=8, full=1 on the 8th edge. A 9th shift with sin_r=1 -> q=8'hA6, cnt=8, full=1.
- Load then left shift: mode=11, d=8'h81 -> q=8'h81, cnt=0. Then mode=10, sin_l=0 -> q=8'h02, cnt=1, sout_l=0.
- Direction change: 3 right shifts (cnt=3), then 1 left shift -> cnt=1, full=0.
- Async reset mid-operation: assert rst between clock edges after 5 shifts -> q=8'h00, cnt=0 immediately, without waiting for clk.
- With USR_ROTATE_EN: load 8'h81, rot=1, mode=01 for 1 edge -> q=8'hC0. Then mode=10 for 2 edges -> q=8'h03, cnt=2.
